if_fetch: RTL

Instruction-fetch stage directly upstream of the decode stage. Owns the program counter, drives the instruction-cache request, and presents the raw 16-bit instruction and its next-PC to decode. Applies decode back-pressure (`stall_IM_ID`) and EX-stage flow changes. Holds the cache address stable across misses, so a redirect that arrives mid-miss is parked and applied once the cache is ready.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_fetch_if.sv | 14 +
 rtl/if_redirect_hold.sv | 32 +++
 rtl/if_fetch.sv | 112 +++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      MISS  = 2'd1,
      REDIR = 2'd2,
      HALT  = 2'd3
   } if_state_e;

   localparam logic [15:0] NOP_INSTR      = 16'hB000;
   localparam logic [3:0]  HLT_OPC        = 4'hF;
   localparam logic [15:0] RST_PC_DEFAULT = 16'h0000;

   function automatic logic is_hlt(input logic [15:0] word);
      return word[15:12] == HLT_OPC;
   endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-cache request/response bundle between fetch (master) and cache (slave).
interface if_fetch_if #(
   parameter int unsigned PC_W = 16
) ();

   logic [PC_W-1:0] i_addr;
   logic            i_re;
   logic [15:0]     i_data;
   logic            i_rdy;

   modport master (output i_addr, i_re, input i_data, i_rdy);
   modport slave  (input i_addr, i_re, output i_data, i_rdy);

endinterface

// File: rtl/if_redirect_hold.sv
// Parks a redirect target that arrives while a cache miss is outstanding.
module if_redirect_hold
   import if_pkg::*;
#(
   parameter int unsigned PC_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  if_state_e       state,
   input  logic            i_rdy,
   input  logic            flow_change,
   input  logic [PC_W-1:0] dst_pc,
   output logic [PC_W-1:0] hold_pc,
   output logic            take
);

   logic capture;

   // A new redirect always overwrites the parked target, so the latest one wins.
   always_comb begin
      capture = flow_change && ((state == MISS && !i_rdy) || state == REDIR);
      take    = (state == REDIR) && !flow_change && i_rdy;
   end

   always_ff @(posedge clk) begin
      if (rst)
         hold_pc <= '0;
      else if (capture)
         hold_pc <= dst_pc;
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the I-cache, feeds decode.
// IF_PERF_CNT_EN adds saturating fetch/miss performance counters.
module if_fetch
   import if_pkg::*;
#(
   parameter int unsigned     PC_W   = 16,
   parameter logic [PC_W-1:0] RST_PC = PC_W'(RST_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   if_fetch_if.master      ic,
   input  logic            stall_IM_ID,
   input  logic            flow_change_ID_EX,
   input  logic [PC_W-1:0] dst_pc,
   output logic [15:0]     instr,
   output logic [PC_W-1:0] nxt_pc
`ifdef IF_PERF_CNT_EN
   ,
   output logic [15:0]     fetch_cnt,
   output logic [15:0]     miss_cnt
`endif
);

   if_state_e       state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt, hold_pc;
   logic            accept, take, re;

   if_redirect_hold #(.PC_W(PC_W)) u_hold (
      .clk         (clk),
      .rst         (rst),
      .state       (state),
      .i_rdy       (ic.i_rdy),
      .flow_change (flow_change_ID_EX),
      .dst_pc      (dst_pc),
      .hold_pc     (hold_pc),
      .take        (take)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
         pc    <= RST_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      accept    = ic.i_rdy && !stall_IM_ID;
      case (state)
         // A miss that resolves this cycle is handled exactly like a normal fetch.
         FETCH, MISS: begin
            if (state == FETCH || ic.i_rdy) begin
               state_nxt = FETCH;
               if (flow_change_ID_EX)
                  pc_nxt = dst_pc;
               else if (!ic.i_rdy)
                  state_nxt = MISS;
               else if (accept) begin
                  pc_nxt = pc + PC_W'(1);
                  if (is_hlt(ic.i_data))
                     state_nxt = HALT;
               end
            end else if (flow_change_ID_EX) begin
               state_nxt = REDIR;
            end
         end
         REDIR: begin
            if (take) begin
               pc_nxt    = hold_pc;
               state_nxt = FETCH;
            end
         end
         HALT: begin
            if (flow_change_ID_EX) begin
               pc_nxt    = dst_pc;
               state_nxt = FETCH;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      re        = !rst && (state != HALT);
      ic.i_re   = re;
      ic.i_addr = pc;
      nxt_pc    = pc + PC_W'(1);
      if (!rst && (state == FETCH || state == MISS) && ic.i_rdy)
         instr = ic.i_data;
      else
         instr = NOP_INSTR;
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= '0;
         miss_cnt  <= '0;
      end else begin
         if (accept && fetch_cnt != '1)
            fetch_cnt <= fetch_cnt + 16'd1;
         if (re && !ic.i_rdy && miss_cnt != '1)
            miss_cnt <= miss_cnt + 16'd1;
      end
   end
`endif

endmodule
